// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: datapath widths, reset PC,
// fetch FSM state encoding and control_signal bit positions.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [7:0] RESET_PC = 8'h00;

    // Fetch FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Positions of the fetch controls inside the control unit's control_signal bus
    localparam int CTRL_IR_LOAD_BIT = 0;
    localparam int CTRL_PC_JUMP_BIT = 1;

endpackage

// File: rtl/ir_prefetch_fifo.sv
// Small synchronous prefetch FIFO holding {opcode byte, fetch address} pairs.
// Head entry is visible combinationally so the IR can load on the pop edge.
// Flush has priority over push and pop. Async active-low reset.
module ir_prefetch_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head_data,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_pop  = pop & ~flush & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);

    assign head_data = data_mem[rd_ptr_q];
    assign head_addr = addr_mem[rd_ptr_q];

    // Entry storage: written on push, no reset needed since count gates reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr_q] <= push_data;
            addr_mem[wr_ptr_q] <= push_addr;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ir_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads opcode bytes from
// instruction memory over a req/ack handshake (one request outstanding),
// buffers them in a prefetch FIFO and loads the instruction register on
// ir_load. pc_jump redirects fetch and flushes everything in flight.
// Optional build macro IR_FETCH_BYPASS_EN: an acknowledged byte goes straight
// into the IR when the FIFO is empty and ir_load is waiting.
module ir_fetch_unit #(
    parameter int              ADDR_W     = cpu_pkg::ADDR_W,
    parameter int              DATA_W     = cpu_pkg::DATA_W,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              ir_load,
    input  logic              pc_jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] data_from_ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              fetch_stall
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;

    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_addr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_after;
    logic              fifo_full, fifo_empty;
    logic              fifo_push, fifo_pop;
    logic              ack_live, bypass;
    logic              space_after;

    // Request line is simply "a read is in flight" (REQ or DRAIN)
    assign mem_rd_req = (state_q != ST_IDLE);
    assign mem_addr   = mem_addr_q;

    // Only an ack for a live (non-abandoned) request delivers a byte
    assign ack_live = (state_q == ST_REQ) & mem_rd_ack;

`ifdef IR_FETCH_BYPASS_EN
    assign bypass = ack_live & ir_load & ~pc_jump & fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_pop    = ir_load & ~pc_jump & ~fifo_empty;
    assign fifo_push   = ack_live & ~pc_jump & ~bypass;
    assign fetch_stall = ir_load & ~pc_jump & fifo_empty & ~bypass;

    // Occupancy after this edge decides whether the next request may issue back-to-back
    always_comb begin
        count_after = fifo_count;
        case ({fifo_push, fifo_pop})
            2'b10:   count_after = fifo_count + CNT_W'(1);
            2'b01:   count_after = fifo_count - CNT_W'(1);
            default: count_after = fifo_count;
        endcase
    end
    assign space_after = (count_after < CNT_W'(FIFO_DEPTH));

    ir_prefetch_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_rd_data),
        .push_addr (mem_addr_q),
        .pop       (fifo_pop),
        .flush     (pc_jump),
        .head_data (head_data),
        .head_addr (head_addr),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fetch FSM: issue reads while there is room, abandon in-flight reads on a jump
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (pc_jump) begin
                    fetch_pc_d = jump_addr;
                end else if (!fifo_full) begin
                    mem_addr_d = fetch_pc_q;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_rd_ack) begin
                    if (pc_jump) begin
                        fetch_pc_d = jump_addr;
                        state_d    = ST_IDLE;
                    end else begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                        if (space_after) begin
                            mem_addr_d = fetch_pc_q + ADDR_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (pc_jump) begin
                    fetch_pc_d = jump_addr;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Old request still owns the bus; its data is thrown away on ack
                if (pc_jump)    fetch_pc_d = jump_addr;
                if (mem_rd_ack) state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction register: jump invalidates, otherwise load from bypass or FIFO head
    always_comb begin
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        if (pc_jump) begin
            ir_valid_d = 1'b0;
        end else if (bypass) begin
            ir_data_d  = mem_rd_data;
            ir_pc_d    = mem_addr_q;
            ir_valid_d = 1'b1;
        end else if (fifo_pop) begin
            ir_data_d  = head_data;
            ir_pc_d    = head_addr;
            ir_valid_d = 1'b1;
        end
    end

    // State registers; reset abandons any in-flight read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign data_from_ir = ir_data_q;
    assign ir_pc        = ir_pc_q;
    assign ir_valid     = ir_valid_q;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Bench for ir_fetch_unit: directed vector table, hand-written corner
// sequences and a randomized run checked against a program-order model.
`timescale 1ns/1ps
module tb_ir_fetch_unit;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic       mem_rd_req, mem_rd_ack, ir_load, pc_jump, ir_valid, fetch_stall;
    logic [7:0] mem_addr, mem_rd_data, jump_addr, data_from_ir, ir_pc;

    // second DUT starting at RESET_PC = FE with a zero-wait memory
    logic       req2, ack2, ld2, valid2, stall2;
    logic [7:0] addr2, rdata2, irdata2, irpc2;

    ir_fetch_unit #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .ir_load(ir_load),
        .pc_jump(pc_jump), .jump_addr(jump_addr), .data_from_ir(data_from_ir),
        .ir_valid(ir_valid), .ir_pc(ir_pc), .fetch_stall(fetch_stall));

    ir_fetch_unit #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(DEPTH), .RESET_PC(8'hFE)) dut2 (
        .clk(clk), .rst(rst), .mem_rd_req(req2), .mem_addr(addr2),
        .mem_rd_ack(ack2), .mem_rd_data(rdata2), .ir_load(ld2),
        .pc_jump(1'b0), .jump_addr(8'h00), .data_from_ir(irdata2),
        .ir_valid(valid2), .ir_pc(irpc2), .fetch_stall(stall2));

    assign ack2   = req2;
    assign rdata2 = addr2 ^ 8'hA5;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [7:0] mem [256];
    int         lat = 0;
    int         wcnt = 0;
    bit         lat_rand = 0;
    bit         hold_en = 0;
    logic [7:0] hold_addr = 8'h00;

    task automatic mem_resp();
        if (!mem_rd_req) begin
            mem_rd_ack = 1'b0;
            wcnt = 0;
        end else if (hold_en && mem_addr == hold_addr) begin
            mem_rd_ack = 1'b0;
        end else if (wcnt >= lat) begin
            mem_rd_ack  = 1'b1;
            mem_rd_data = mem[mem_addr];
            wcnt = 0;
            if (lat_rand) lat = $urandom_range(0, 3);
        end else begin
            mem_rd_ack = 1'b0;
            wcnt++;
        end
        if (!mem_rd_ack) mem_rd_data = 8'($urandom);
    endtask

    // ---------------- reference model ----------------
    // Bytes are expected in program order from the last jump target; a read
    // that was in flight when a jump arrived is stale and its data is dropped.
    logic [15:0] q [$];
    logic [7:0]  m_next;
    bit          m_stale;
    logic [7:0]  exp_data, exp_pc;
    logic        exp_valid;
    logic        prev_req, prev_ack;
    logic [7:0]  prev_addr;
    logic        s_stall, s_req;
    logic [7:0]  s_addr;

    task automatic model_reset();
        q.delete();
        m_next = 8'h00; m_stale = 0;
        exp_data = 8'h00; exp_pc = 8'h00; exp_valid = 1'b0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ir_load = 1'b0; pc_jump = 1'b0; jump_addr = 8'h00;
        mem_rd_ack = 1'b0; mem_rd_data = 8'h00; ld2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", mem_rd_req, 0);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_data", data_from_ir, 8'h00);
        check("rst_valid", ir_valid, 0);
        check("rst_irpc", ir_pc, 8'h00);
        check("rst_addr2", addr2, 8'hFE);
        model_reset();
        lat = 0; wcnt = 0; lat_rand = 0; hold_en = 0;
        rst = 1'b1;
    endtask

    // One clock cycle on the main DUT; call at posedge+1.
    task automatic step(input logic ld, input logic jmp, input logic [7:0] ja);
        logic acc, byp, ex_stall;
        logic [15:0] head;
        mem_resp();
        ir_load = ld; pc_jump = jmp; jump_addr = ja;
        #1;
        s_stall = fetch_stall; s_req = mem_rd_req; s_addr = mem_addr;
        if (prev_req && !prev_ack) begin
            check("req_hold", mem_rd_req, 1);
            check("addr_hold", mem_addr, prev_addr);
        end
        acc = mem_rd_req && mem_rd_ack;
        byp = 1'b0;
`ifdef IR_FETCH_BYPASS_EN
        byp = acc && !m_stale && ld && !jmp && (q.size() == 0);
`endif
        ex_stall = ld && !jmp && (q.size() == 0) && !byp;
        check("fetch_stall", fetch_stall, ex_stall);
        if (jmp) begin
            q.delete();
            exp_valid = 1'b0;
            m_next = ja;
            m_stale = mem_rd_req && !mem_rd_ack;
        end else begin
            if (ld && q.size() > 0) begin
                head = q.pop_front();
                exp_data = head[15:8]; exp_pc = head[7:0]; exp_valid = 1'b1;
            end
            if (acc && m_stale) begin
                m_stale = 0;
            end else if (acc) begin
                check("fetch_addr", mem_addr, m_next);
                m_next = m_next + 8'd1;
                if (byp) begin
                    exp_data = mem[mem_addr]; exp_pc = mem_addr; exp_valid = 1'b1;
                end else begin
                    q.push_back({mem[mem_addr], mem_addr});
                    check("fifo_room", q.size() <= DEPTH, 1);
                end
            end
        end
        prev_req = mem_rd_req; prev_ack = mem_rd_ack; prev_addr = mem_addr;
        @(posedge clk);
        #1;
        check("ir_valid", ir_valid, exp_valid);
        check("ir_data", data_from_ir, exp_data);
        check("ir_pc", ir_pc, exp_pc);
    endtask

    typedef struct {
        logic       ld;
        logic       stall;
        logic       req;
        logic [7:0] addr;
        logic       valid;
        logic [7:0] data;
        logic [7:0] pc;
    } vec_t;

    vec_t t1 [5];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit found;
        int idx;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

        // zero-wait streaming, ir_load held from reset release
        t1[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
`ifdef IR_FETCH_BYPASS_EN
        t1[1] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5, 8'h00};
        t1[2] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 8'hA4, 8'h01};
        t1[3] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 8'hA7, 8'h02};
        t1[4] = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 8'hA6, 8'h03};
`else
        t1[1] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00};
        t1[2] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 8'hA5, 8'h00};
        t1[3] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 8'hA4, 8'h01};
        t1[4] = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 8'hA7, 8'h02};
`endif

        // ---- RESET_PC = FE: fetch FE, FF, stop when full, then wrap to 00 ----
        do_reset();
        #1;
        check("wrap_req_c0", req2, 0);
        @(posedge clk); #1;
        check("wrap_req_e1", req2, 1);
        check("wrap_addr_e1", addr2, 8'hFE);
        @(posedge clk); #1;
        check("wrap_addr_e2", addr2, 8'hFF);
        @(posedge clk); #1;
        check("wrap_full_e3", req2, 0);
        @(posedge clk); #1;
        check("wrap_full_e4", req2, 0);
        ld2 = 1'b1;
        #1;
        check("wrap_stall", stall2, 0);
        @(posedge clk); #1;
        ld2 = 1'b0;
        check("wrap_ir_fe", irdata2, 8'h5B);
        check("wrap_pc_fe", irpc2, 8'hFE);
        check("wrap_valid", valid2, 1);
        check("wrap_req_e5", req2, 0);
        @(posedge clk); #1;
        check("wrap_req_e6", req2, 1);
        check("wrap_addr_00", addr2, 8'h00);
        @(posedge clk); #1;
        ld2 = 1'b1;
        @(posedge clk); #1;
        check("wrap_ir_ff", irdata2, 8'h5A);
        check("wrap_pc_ff", irpc2, 8'hFF);
        @(posedge clk); #1;
        ld2 = 1'b0;
        check("wrap_ir_00", irdata2, 8'hA5);
        check("wrap_pc_00", irpc2, 8'h00);

        // ---- table: zero-wait streaming ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(t1[i].ld, 1'b0, 8'h00);
            check($sformatf("t1_stall[%0d]", i), s_stall, t1[i].stall);
            check($sformatf("t1_req[%0d]", i), s_req, t1[i].req);
            if (t1[i].req) check($sformatf("t1_addr[%0d]", i), s_addr, t1[i].addr);
            check($sformatf("t1_valid[%0d]", i), ir_valid, t1[i].valid);
            check($sformatf("t1_data[%0d]", i), data_from_ir, t1[i].data);
            check($sformatf("t1_pc[%0d]", i), ir_pc, t1[i].pc);
        end
        repeat (6) step(1'b1, 1'b0, 8'h00);

        // ---- 3-cycle memory, ir_load held ----
        do_reset();
        lat = 3;
        found = 0; idx = -1;
        for (int c = 0; c < 20 && !found; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if (prev_req && prev_ack) begin
                found = 1; idx = c;
            end else begin
                check("wait_stall", s_stall, 1);
                if (s_req) check("wait_addr", s_addr, 8'h00);
            end
        end
        check("ack_seen", found, 1);
        check("ack_cycle", idx, 4);
        repeat (12) step(1'b1, 1'b0, 8'h00);

        // ---- jump to 40 while the request to 05 is pending ----
        do_reset();
        hold_en = 1; hold_addr = 8'h05;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if (mem_rd_req && mem_addr == 8'h05) found = 1;
        end
        check("reach_05", found, 1);
        step(1'b1, 1'b1, 8'h40);
        check("jump_valid_drop", ir_valid, 0);
        step(1'b1, 1'b0, 8'h00);
        check("drain_req", s_req, 1);
        check("drain_addr", s_addr, 8'h05);
        hold_en = 0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if (mem_rd_req && mem_addr != 8'h05) found = 1;
        end
        check("post_jump_req", found, 1);
        check("post_jump_addr", mem_addr, 8'h40);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            step(1'b1, 1'b0, 8'h00);
            if (ir_valid) found = 1;
        end
        check("post_jump_valid", found, 1);
        check("post_jump_ir", data_from_ir, 8'hE5);
        check("post_jump_pc", ir_pc, 8'h40);

        // ---- ir_load and pc_jump together with a non-empty FIFO ----
        do_reset();
        repeat (6) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("pre_jump_ir", data_from_ir, 8'hA5);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h80);
        check("jl_stall", s_stall, 0);
        check("jl_valid", ir_valid, 0);
        check("jl_data", data_from_ir, 8'hA5);
        check("jl_pc", ir_pc, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("jl_fifo_empty", s_stall, 1);
        repeat (6) step(1'b1, 1'b0, 8'h00);

        // ---- empty FIFO, ack and ir_load in the same cycle, data 3C ----
        do_reset();
        mem[0] = 8'h3C;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
`ifdef IR_FETCH_BYPASS_EN
        check("byp_stall", s_stall, 0);
        check("byp_ir", data_from_ir, 8'h3C);
        step(1'b1, 1'b0, 8'h00);
        check("byp_count0", s_stall, 0);
        check("byp_ir_next", data_from_ir, 8'hA4);
`else
        check("nobyp_stall", s_stall, 1);
        check("nobyp_valid", ir_valid, 0);
        step(1'b1, 1'b0, 8'h00);
        check("nobyp_stall2", s_stall, 0);
        check("nobyp_ir", data_from_ir, 8'h3C);
        check("nobyp_pc", ir_pc, 8'h00);
`endif
        mem[0] = 8'hA5;

        // ---- randomized run with random latency, loads and jumps ----
        do_reset();
        lat_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset();
                lat_rand = 1;
            end
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Supplier side of the control unit's instruction input. Owns the program counter and fetches opcode bytes from instruction memory over a req/ack read handshake.
- Buffers fetched bytes in a small prefetch FIFO and loads the instruction register when the control unit asserts its IR-load control bit.
- data_from_ir drives the control unit's data_from_ir input directly. ir_load, pc_jump and jump_addr are decoded from the control unit's control_signal bus.

Parameters:
- ADDR_W, 8, width of the PC and memory address.
- DATA_W, 8, opcode byte width; must match the control unit's data_from_ir width.
- FIFO_DEPTH, 2, prefetch entries; power of 2, at least 2.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_rd_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; valid while mem_rd_req=1.
- mem_rd_ack  in  1  one-cycle acknowledge; mem_rd_data valid in the same cycle.
- mem_rd_data  in  DATA_W  fetched byte.
- ir_load  in  1  control unit requests the next opcode into the IR.
- pc_jump  in  1  redirect fetch; flush the pipeline.
- jump_addr  in  ADDR_W  redirect target, sampled when pc_jump=1.
- data_from_ir  out  DATA_W  instruction register contents, to the control unit.
- ir_valid  out  1  data_from_ir holds a valid opcode.
- ir_pc  out  ADDR_W  address the current IR byte was fetched from.
- fetch_stall  out  1  combinational: ir_load=1 and the IR cannot load this cycle.

Behaviour:
- Reset (rst=0, asynchronous), all registered:
  - mem_rd_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - data_from_ir=0, ir_valid=0, ir_pc=0.
  - FIFO empty, state=IDLE.
- Reset asserted mid-transaction abandons it. The memory side must tolerate mem_rd_req dropping without an ack.
- Handshake:
  - Once mem_rd_req=1, mem_rd_req and mem_addr stay stable until the cycle mem_rd_ack=1.
  - At most one request is outstanding.
  - mem_rd_ack while mem_rd_req=0 is ignored.
- Space rule: a request issues only if FIFO count plus outstanding requests is below FIFO_DEPTH, so an ack always finds room.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE, req=0:
    - pc_jump: fetch_pc<=jump_addr, stay IDLE.
    - Otherwise, if space: mem_addr<=fetch_pc, go REQ.
  - REQ, req=1:
    - ack and no pc_jump: push {mem_rd_data, mem_addr}, fetch_pc<=fetch_pc+1. If space remains, mem_addr<=fetch_pc+1 and stay REQ; else go IDLE.
    - ack and pc_jump: discard the data, fetch_pc<=jump_addr, go IDLE.
    - No ack and pc_jump: fetch_pc<=jump_addr, go DRAIN.
  - DRAIN, req=1 on the old address:
    - On ack: discard the data, go IDLE.
    - Further pc_jump: overwrite fetch_pc, stay DRAIN.
- PC arithmetic: modulo 2^ADDR_W; 0xFF+1 wraps to 0x00 at the default width.
- IR load:
  - ir_load with FIFO non-empty: pop the head. Next edge: data_from_ir<=byte, ir_pc<=addr, ir_valid<=1.
  - ir_load with FIFO empty: no change, fetch_stall=1. The control unit holds ir_load until fetch_stall=0.
  - Push and pop in the same cycle are both performed; count is unchanged.
- pc_jump, highest priority:
  - FIFO flushed same edge, ir_valid<=0, data_from_ir unchanged.
  - ir_load in the same cycle is ignored and fetch_stall=0.
- Latency with a zero-wait memory (ack in the same cycle as req), no bypass:
  - Reset release to first req: 1 cycle.
  - First byte into the FIFO: the following edge.
  - ir_load to ir_valid: 1 edge.

Optional Feature:
- Macro: IR_FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, state=REQ, mem_rd_ack=1, ir_load=1 and pc_jump=0, mem_rd_data goes directly into the IR on that edge. The byte is not pushed, and fetch_stall=0 that cycle.
- Undefined: the byte is pushed and fetch_stall=1; the IR loads one cycle later.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, DATA_W, RESET_PC.
  - The fetch FSM state encoding (IDLE=2'd0, REQ=2'd1, DRAIN=2'd2).
  - Control-signal bit indices for ir_load and pc_jump within control_signal.
- Sub-module ir_prefetch_fifo: synchronous FIFO of {DATA_W, ADDR_W} entries with push, pop, flush, count, full and empty, async active-low reset.

Test Plan:
- Reset release, zero-wait memory returning mem[a]=a^8'hA5, ir_load held high:
  - mem_addr sequence 00,01,02…
  - data_from_ir sequence A5,A4,A7… with ir_pc 00,01,02.
- Memory acks 3 cycles after req, ir_load held:
  - fetch_stall=1 until the first ack.
  - mem_rd_req and mem_addr stay stable through the wait cycles.
  - Exactly one outstanding request at any time.
- pc_jump to 8'h40 while a request to 8'h05 is pending:
  - Goes to DRAIN; the byte from 05 is discarded.
  - Next request is to 40; ir_valid drops the cycle after the jump.
  - Next IR is mem[40] with ir_pc=40.
- Start at RESET_PC=8'hFE, stall ir_load:
  - Fetches FE, FF, then stops with the FIFO full.
  - After a pop, fetches 00; the wrap is verified.
- Same-cycle ir_load and pc_jump with a non-empty FIFO:
  - IR unchanged, ir_valid=0, FIFO empty, fetch_stall=0.
- With IR_FETCH_BYPASS_EN, empty FIFO, ack and ir_load in the same cycle, data 8'h3C:
  - data_from_ir=3C next edge, FIFO count stays 0.
  - Without the macro the IR loads one edge later.
